// File: rtl/axi4_lite_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_master
// Single-beat AXI4-Lite master with independent read and write channel FSMs.
// A one-cycle start request launches a transfer; completion is reported with a
// one-cycle done pulse, the registered read data and the slave error bit.
//
// Ports
//   clk_i, arst_ni                 clock, asynchronous active-low reset
//   start_read_i, start_write_i    one-cycle transfer requests
//   addr_i, data_i, strb_i         request address, write data, write strobe
//   data_o                         last read data
//   read_done_o, write_done_o      one-cycle completion pulses
//   read_busy_o, write_busy_o      channel FSM not idle
//   read_err_o, write_err_o        RESP[1] of the completed transfer
//   AR_*, R_*, AW_*, W_*, B_*      AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axi4_lite_master #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          arst_ni,
  input  logic                          start_read_i,
  input  logic                          start_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]     data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   strb_i,
  output logic [AXI_DATA_WIDTH-1:0]     data_o,
  output logic                          read_done_o,
  output logic                          write_done_o,
  output logic                          read_busy_o,
  output logic                          write_busy_o,
  output logic                          read_err_o,
  output logic                          write_err_o,
  // read address channel
  output logic                          AR_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR,
  output logic [2:0]                    AR_PROT,
  input  logic                          AR_READY,
  // read data channel
  input  logic [AXI_DATA_WIDTH-1:0]     R_DATA,
  input  logic [1:0]                    R_RESP,
  input  logic                          R_VALID,
  output logic                          R_READY,
  // write address channel
  output logic                          AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
  output logic [2:0]                    AW_PROT,
  input  logic                          AW_READY,
  // write data channel
  output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
  output logic                          W_VALID,
  input  logic                          W_READY,
  // write response channel
  input  logic [1:0]                    B_RESP,
  input  logic                          B_VALID,
  output logic                          B_READY
);

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR_DATA, WR_RESP} wr_state_t;

  rd_state_t r_rd_state;
  wr_state_t r_wr_state;
  logic      r_aw_done;
  logic      r_w_done;
  logic      w_aw_fin;
  logic      w_w_fin;
  logic      w_unused;

  // Only the error bit of each response is reported.
  assign w_unused = ^{R_RESP[0], B_RESP[0]};

  assign AR_PROT      = 3'b000;
  assign AW_PROT      = 3'b000;
  assign read_busy_o  = (r_rd_state != RD_IDLE);
  assign write_busy_o = (r_wr_state != WR_IDLE);

  // A channel counts as finished if it already handshook or handshakes now.
  assign w_aw_fin = r_aw_done | (AW_VALID & AW_READY);
  assign w_w_fin  = r_w_done  | (W_VALID  & W_READY);

  // Read channel FSM
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_rd_state  <= RD_IDLE;
      AR_VALID    <= 1'b0;
      AR_ADDR     <= '0;
      R_READY     <= 1'b0;
      data_o      <= '0;
      read_done_o <= 1'b0;
      read_err_o  <= 1'b0;
    end else begin
      read_done_o <= 1'b0;
      case (r_rd_state)
        RD_IDLE: begin
          if (start_read_i) begin
            AR_ADDR    <= addr_i;
            AR_VALID   <= 1'b1;
            r_rd_state <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (AR_READY) begin
            AR_VALID   <= 1'b0;
            R_READY    <= 1'b1;
            r_rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (R_VALID) begin
            R_READY     <= 1'b0;
            data_o      <= R_DATA;
            read_err_o  <= R_RESP[1];
            read_done_o <= 1'b1;
            r_rd_state  <= RD_IDLE;
          end
        end
        default: begin
          AR_VALID   <= 1'b0;
          R_READY    <= 1'b0;
          r_rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM; AW and W complete independently before the response
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_wr_state   <= WR_IDLE;
      AW_VALID     <= 1'b0;
      AW_ADDR      <= '0;
      W_VALID      <= 1'b0;
      W_DATA       <= '0;
      W_STRB       <= '0;
      B_READY      <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      write_done_o <= 1'b0;
      write_err_o  <= 1'b0;
    end else begin
      write_done_o <= 1'b0;
      case (r_wr_state)
        WR_IDLE: begin
          if (start_write_i) begin
            AW_ADDR    <= addr_i;
            W_DATA     <= data_i;
            W_STRB     <= strb_i;
            AW_VALID   <= 1'b1;
            W_VALID    <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_state <= WR_ADDR_DATA;
          end
        end
        WR_ADDR_DATA: begin
          if (AW_VALID && AW_READY) begin
            AW_VALID  <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (W_VALID && W_READY) begin
            W_VALID  <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            B_READY    <= 1'b1;
            r_wr_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (B_VALID) begin
            B_READY      <= 1'b0;
            write_err_o  <= B_RESP[1];
            write_done_o <= 1'b1;
            r_wr_state   <= WR_IDLE;
          end
        end
        default: begin
          AW_VALID   <= 1'b0;
          W_VALID    <= 1'b0;
          B_READY    <= 1'b0;
          r_wr_state <= WR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master
// Directed and randomized bench for axi4_lite_master. A delay-programmable
// AXI4-Lite slave responds to the master; transaction-level expectations are
// compared against what the slave observed and what the master reported.
// -----------------------------------------------------------------------------
module tb_axi4_lite_master;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          start_read_i = 1'b0;
  logic          start_write_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] data_i = '0;
  logic [SW-1:0] strb_i = '0;
  logic [DW-1:0] data_o;
  logic          read_done_o, write_done_o, read_busy_o, write_busy_o;
  logic          read_err_o, write_err_o;
  logic          AR_VALID, AR_READY, R_VALID, R_READY;
  logic [AW-1:0] AR_ADDR, AW_ADDR;
  logic [2:0]    AR_PROT, AW_PROT;
  logic [DW-1:0] R_DATA, W_DATA;
  logic [1:0]    R_RESP, B_RESP;
  logic          AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;
  logic [SW-1:0] W_STRB;

  axi4_lite_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .start_read_i(start_read_i), .start_write_i(start_write_i),
    .addr_i(addr_i), .data_i(data_i), .strb_i(strb_i), .data_o(data_o),
    .read_done_o(read_done_o), .write_done_o(write_done_o),
    .read_busy_o(read_busy_o), .write_busy_o(write_busy_o),
    .read_err_o(read_err_o), .write_err_o(write_err_o),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY)
  );

  always #5 clk_i = ~clk_i;

  // Slave programming (set by the main sequence before each transfer)
  logic [7:0]    ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [DW-1:0] rd_data_next = '0;
  logic [1:0]    rd_resp_next = '0, wr_resp_next = '0;

  // Slave state and what it observed
  logic [7:0]    ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic          r_pend, b_pend, aw_got, w_got, aw_hs, w_hs;
  logic [AW-1:0] ar_addr_seen, aw_addr_seen;
  logic [DW-1:0] w_data_seen;
  logic [SW-1:0] w_strb_seen;

  assign AR_READY = AR_VALID && (ar_cnt >= ar_dly);
  assign AW_READY = AW_VALID && (aw_cnt >= aw_dly);
  assign W_READY  = W_VALID  && (w_cnt  >= w_dly);
  assign R_VALID  = r_pend && (r_cnt >= r_dly);
  assign B_VALID  = b_pend && (b_cnt >= b_dly);
  assign aw_hs    = AW_VALID && AW_READY;
  assign w_hs     = W_VALID && W_READY;

  always @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 0; b_pend <= 0; aw_got <= 0; w_got <= 0;
      R_DATA <= '0; R_RESP <= '0; B_RESP <= '0;
      ar_addr_seen <= '0; aw_addr_seen <= '0; w_data_seen <= '0; w_strb_seen <= '0;
    end else begin
      ar_cnt <= (AR_VALID && !AR_READY) ? ar_cnt + 8'd1 : 8'd0;
      aw_cnt <= (AW_VALID && !AW_READY) ? aw_cnt + 8'd1 : 8'd0;
      w_cnt  <= (W_VALID && !W_READY) ? w_cnt + 8'd1 : 8'd0;
      if (AR_VALID && AR_READY) begin
        r_pend <= 1; r_cnt <= 0;
        R_DATA <= rd_data_next; R_RESP <= rd_resp_next;
        ar_addr_seen <= AR_ADDR;
      end else if (r_pend) begin
        if (R_VALID && R_READY) r_pend <= 0;
        else r_cnt <= r_cnt + 8'd1;
      end
      if (aw_hs) begin aw_got <= 1; aw_addr_seen <= AW_ADDR; end
      if (w_hs) begin w_got <= 1; w_data_seen <= W_DATA; w_strb_seen <= W_STRB; end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        b_pend <= 1; b_cnt <= 0; aw_got <= 0; w_got <= 0; B_RESP <= wr_resp_next;
      end else if (b_pend) begin
        if (B_VALID && B_READY) b_pend <= 0;
        else b_cnt <= b_cnt + 8'd1;
      end
    end
  end

  // Monitor: done pulses, values reported with them, VALID stability
  int            rd_done_cnt = 0, wr_done_cnt = 0, viol = 0;
  logic          rd_err_at_done = 0, wr_err_at_done = 0;
  logic [DW-1:0] rd_data_at_done = '0;
  logic          p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
  logic [AW-1:0] p_ara = '0, p_awa = '0;
  logic [DW-1:0] p_wd = '0;
  logic [SW-1:0] p_ws = '0;

  always @(negedge clk_i) begin
    if (!arst_ni) begin
      p_arv = 0; p_awv = 0; p_wv = 0;
    end else begin
      if (read_done_o) begin
        rd_done_cnt++; rd_err_at_done = read_err_o; rd_data_at_done = data_o;
      end
      if (write_done_o) begin
        wr_done_cnt++; wr_err_at_done = write_err_o;
      end
      if (p_arv && !p_arr && (!AR_VALID || AR_ADDR !== p_ara)) viol++;
      if (p_awv && !p_awr && (!AW_VALID || AW_ADDR !== p_awa)) viol++;
      if (p_wv && !p_wr && (!W_VALID || W_DATA !== p_wd || W_STRB !== p_ws)) viol++;
      p_arv = AR_VALID; p_arr = AR_READY; p_ara = AR_ADDR;
      p_awv = AW_VALID; p_awr = AW_READY; p_awa = AW_ADDR;
      p_wv = W_VALID; p_wr = W_READY; p_wd = W_DATA; p_ws = W_STRB;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_counts(input int rd_target, input int wr_target, input string tag);
    int n = 0;
    while ((rd_done_cnt < rd_target || wr_done_cnt < wr_target) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      check({tag, "_timeout_rd"}, rd_done_cnt, rd_target);
      check({tag, "_timeout_wr"}, wr_done_cnt, wr_target);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valids"}, {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}, 0);
    check({tag, "_status"}, {read_done_o, write_done_o, read_busy_o, write_busy_o,
                             read_err_o, write_err_o}, 0);
    check({tag, "_data_o"}, data_o, 0);
    check({tag, "_ar_addr"}, AR_ADDR, 0);
    check({tag, "_aw_addr"}, AW_ADDR, 0);
    check({tag, "_w_data"}, {W_STRB, W_DATA}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_exp, wr_exp, wr_before, op;
    logic [AW-1:0] e_addr, e_waddr;
    logic [DW-1:0] e_rdata, e_wdata;
    logic [SW-1:0] e_strb;
    logic [1:0]    e_rresp, e_bresp;

    // Reset state
    repeat (3) tick();
    check_all_zero("reset");
    check("prot", {AR_PROT, AW_PROT}, 0);
    arst_ni = 1'b1;
    tick();

    // Zero-wait read with exact latency, then a start on the done cycle
    addr_i = 64'h1000; rd_data_next = 32'hDEADBEEF; rd_resp_next = 2'b00;
    start_read_i = 1;
    tick(); start_read_i = 0;
    check("rd_c1_arvalid", AR_VALID, 1);
    check("rd_c1_araddr", AR_ADDR, 64'h1000);
    tick();
    check("rd_c2_rready", R_READY, 1);
    tick();
    check("rd_c3_done", read_done_o, 1);
    check("rd_c3_data", data_o, 32'hDEADBEEF);
    check("rd_c3_err", read_err_o, 0);
    check("rd_c3_idle", read_busy_o, 0);
    addr_i = 64'h2000; rd_data_next = 32'h12345678;
    start_read_i = 1;
    tick(); start_read_i = 0;
    check("rd_b2b_done_low", read_done_o, 0);
    check("rd_b2b_accept", {AR_VALID, AR_ADDR}, {1'b1, 64'h2000});
    wait_counts(2, 0, "rd_b2b");
    tick();
    check("rd_b2b_data", rd_data_at_done, 32'h12345678);

    // Simultaneous read and write, zero-wait slave
    addr_i = 64'h3000; data_i = 32'h0BADF00D; strb_i = 4'h5;
    rd_data_next = 32'hA5A5A5A5;
    start_read_i = 1; start_write_i = 1;
    tick(); start_read_i = 0; start_write_i = 0;
    check("both_c1_valid", {AR_VALID, AW_VALID, W_VALID}, 3'b111);
    tick(); tick();
    check("both_c3_done", {read_done_o, write_done_o}, 2'b11);
    check("both_aw_seen", aw_addr_seen, 64'h3000);
    check("both_w_seen", {w_strb_seen, w_data_seen}, {4'h5, 32'h0BADF00D});
    tick();

    // Read with SLVERR
    addr_i = 64'h4000; rd_data_next = 32'h0; rd_resp_next = 2'b10;
    start_read_i = 1; tick(); start_read_i = 0;
    wait_counts(4, 1, "slverr");
    tick();
    check("slverr_err", rd_err_at_done, 1);
    rd_resp_next = 2'b00;

    // AW_READY three cycles after W_READY
    aw_dly = 3; w_dly = 0;
    wr_before = wr_done_cnt;
    addr_i = 64'h5000; data_i = 32'hCAFEF00D; strb_i = 4'hF;
    start_write_i = 1; tick(); start_write_i = 0;
    check("wr_c1_valid", {AW_VALID, W_VALID}, 2'b11);
    tick();
    check("wr_c2_wdrop", {AW_VALID, W_VALID, B_READY}, 3'b100);
    tick();
    check("wr_c3_hold", {AW_VALID, W_VALID, B_READY}, 3'b100);
    tick(); tick();
    check("wr_c5_bready", {AW_VALID, W_VALID, B_READY}, 3'b001);
    tick();
    check("wr_c6_done", write_done_o, 1);
    repeat (5) tick();
    check("wr_single_done", wr_done_cnt - wr_before, 1);
    check("wr_w_seen", {w_strb_seen, w_data_seen}, {4'hF, 32'hCAFEF00D});
    aw_dly = 0;

    // Second start during a stalled DATA phase is ignored
    r_dly = 6; rd_exp = rd_done_cnt + 1;
    addr_i = 64'h6000; rd_data_next = 32'h600D600D;
    start_read_i = 1; tick(); start_read_i = 0;
    tick(); tick();
    addr_i = 64'h7000; start_read_i = 1; tick(); start_read_i = 0;
    check("rd_ignore_addr", {AR_VALID, AR_ADDR}, {1'b0, 64'h6000});
    wait_counts(rd_exp, 0, "rd_ignore");
    repeat (10) tick();
    check("rd_ignore_once", rd_done_cnt, rd_exp);
    check("rd_ignore_data", rd_data_at_done, 32'h600D600D);
    r_dly = 0;

    // Reset during a write address phase
    aw_dly = 5; w_dly = 5; wr_before = wr_done_cnt;
    addr_i = 64'h8000; data_i = 32'h11112222; strb_i = 4'h3;
    start_write_i = 1; tick(); start_write_i = 0;
    tick();
    #2 arst_ni = 0;
    #1 check_all_zero("async_rst");
    tick(); tick();
    arst_ni = 1;
    aw_dly = 0; w_dly = 0;
    repeat (10) tick();
    check("rst_no_done", wr_done_cnt, wr_before);
    addr_i = 64'h9000; data_i = 32'h33334444; strb_i = 4'hC;
    start_write_i = 1; tick(); start_write_i = 0;
    tick(); tick();
    check("rst_new_done", write_done_o, 1);
    check("rst_new_seen", {aw_addr_seen[15:0], w_strb_seen, w_data_seen},
          {16'h9000, 4'hC, 32'h33334444});
    tick();

    // Randomized transfers checked at transaction level
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      ar_dly = 8'($urandom_range(0, 3)); r_dly = 8'($urandom_range(0, 3));
      aw_dly = 8'($urandom_range(0, 3)); w_dly = 8'($urandom_range(0, 3));
      b_dly = 8'($urandom_range(0, 3));
      e_addr = {$urandom, $urandom};
      e_waddr = e_addr;
      e_rdata = $urandom; e_wdata = $urandom; e_strb = 4'($urandom);
      e_rresp = 2'($urandom); e_bresp = 2'($urandom);
      rd_data_next = e_rdata; rd_resp_next = e_rresp; wr_resp_next = e_bresp;
      rd_exp = rd_done_cnt + ((op != 1) ? 1 : 0);
      wr_exp = wr_done_cnt + ((op != 0) ? 1 : 0);
      addr_i = e_addr; data_i = e_wdata; strb_i = e_strb;
      start_read_i = (op != 1); start_write_i = (op != 0);
      tick(); start_read_i = 0; start_write_i = 0;
      tick();
      // Spurious start with different payload; both channels are busy here
      addr_i = ~e_addr; data_i = ~e_wdata;
      start_read_i = (op != 1); start_write_i = (op != 0);
      tick(); start_read_i = 0; start_write_i = 0;
      wait_counts(rd_exp, wr_exp, "rand");
      repeat (4) tick();
      if (op != 1) begin
        check("rand_rd_count", rd_done_cnt, rd_exp);
        check("rand_rd_addr", ar_addr_seen, e_addr);
        check("rand_rd_data", rd_data_at_done, e_rdata);
        check("rand_rd_err", rd_err_at_done, e_rresp[1]);
      end
      if (op != 0) begin
        check("rand_wr_count", wr_done_cnt, wr_exp);
        check("rand_wr_addr", aw_addr_seen, e_waddr);
        check("rand_wr_data", {w_strb_seen, w_data_seen}, {e_strb, e_wdata});
        check("rand_wr_err", wr_err_at_done, e_bresp[1]);
      end
      check("rand_idle", {read_busy_o, write_busy_o}, 0);
    end

    check("valid_stability", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, which sets the address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, which sets the data width; it must be a multiple of 8.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk_i: input, 1 bit, the single clock; all logic on rising edge.
REQ-005 SHALL have port arst_ni: input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have ports start_read_i / start_write_i: input, 1 bit each, one-cycle requests.
REQ-007 SHALL have port addr_i: input, AXI_ADDR_WIDTH, address for the request.
REQ-008 SHALL have port data_i: input, AXI_DATA_WIDTH, write data. Port strb_i: input, AXI_DATA_WIDTH/8, write strobe.
REQ-009 SHALL have port data_o: output, AXI_DATA_WIDTH, last read data (registered).
REQ-010 SHALL have ports read_done_o / write_done_o: output, 1 bit each, one-cycle completion pulses.
REQ-011 SHALL have ports read_busy_o / write_busy_o: output, 1 bit each, high while the channel FSM is not IDLE.
REQ-012 SHALL have ports read_err_o / write_err_o: output, 1 bit each, RESP[1] of the completed transfer, valid with the done pulse.
REQ-013 SHALL have AXI master ports: AR_VALID/AR_ADDR/AR_PROT out, AR_READY in; R_DATA/R_RESP/R_VALID in, R_READY out; AW_VALID/AW_ADDR/AW_PROT out, AW_READY in; W_DATA/W_STRB/W_VALID out, W_READY in; B_RESP/B_VALID in, B_READY out. Widths follow the AXI4-Lite standard.

Function
REQ-014 SHALL use independent read and write FSMs. Read and write SHALL run concurrently, including when both starts arrive in the same cycle.
REQ-015 Read FSM SHALL have states IDLE, ADDR, DATA. Transitions: IDLE->ADDR on start_read_i; ADDR->DATA on AR_VALID&&AR_READY; DATA->IDLE on R_VALID&&R_READY.
REQ-016 On accepting a read, the block SHALL register addr_i into AR_ADDR, and AR_VALID SHALL go high the next cycle.
REQ-017 AR_VALID SHALL stay high and AR_ADDR stable until AR_READY is sampled high. Once raised, VALID is never withdrawn.
REQ-018 R_READY SHALL be high exactly while in the DATA state.
REQ-019 On the R handshake, the block SHALL latch R_DATA into data_o and R_RESP[1] into read_err_o. read_done_o SHALL pulse the following cycle.
REQ-020 Write FSM SHALL have states IDLE, ADDR_DATA, RESP. Transitions: IDLE->ADDR_DATA on start_write_i; ADDR_DATA->RESP once both the AW and W handshakes have completed, in either order or the same cycle; RESP->IDLE on B_VALID&&B_READY.
REQ-021 AW_VALID and W_VALID SHALL both rise the cycle after the start. Each SHALL drop independently after its own handshake; internal aw_done/w_done flags track this.
REQ-022 AW_ADDR, W_DATA and W_STRB SHALL be registered at start and held stable until their handshakes complete.
REQ-023 B_READY SHALL be high exactly while in the RESP state. On the B handshake, write_err_o SHALL take B_RESP[1], and write_done_o SHALL pulse the following cycle.
REQ-024 AR_PROT and AW_PROT SHALL be constant 3'b000.
REQ-025 A start arriving while the corresponding FSM is not IDLE SHALL be ignored, with no queuing.
REQ-026 The minimum read latency, with READY/VALID high immediately, SHALL be: start at cycle 0 -> AR handshake at cycle 1 -> R handshake at cycle 2 -> read_done_o at cycle 3. The write path SHALL have the same latency.
REQ-027 A start arriving in the same cycle as that channel's done pulse SHALL be accepted. The FSM is already IDLE in that cycle.

Reset
REQ-028 Asserting arst_ni low SHALL immediately force both FSMs to IDLE, at any point including mid-transfer.
REQ-029 During reset, all VALID/READY outputs, done, busy and err outputs SHALL be 0. data_o, AR_ADDR, AW_ADDR, W_DATA and W_STRB SHALL be 0.
REQ-030 An aborted transfer SHALL NOT produce a done pulse after reset is released.

Verification
REQ-031 Read with AR_READY=1 and R_VALID=1 immediately, addr_i=0x1000, R_DATA=0xDEADBEEF, R_RESP=00 -> AR_ADDR=0x1000 at cycle 1; data_o=0xDEADBEEF with read_done_o=1 and read_err_o=0 at cycle 3.
REQ-032 Write where AW_READY arrives 3 cycles after W_READY, data 0xCAFEF00D, strb 0xF -> W_VALID drops after its handshake while AW_VALID holds. B_READY rises only after both handshakes. write_done_o pulses once.
REQ-033 Simultaneous start_read_i and start_write_i -> both channels complete, and both done pulses occur at cycle 3 with zero-wait slaves.
REQ-034 Read with R_RESP=2'b10 (SLVERR) -> read_err_o=1 coincident with read_done_o.
REQ-035 Second start_read_i during DATA state with R_VALID stalled -> ignored, AR_ADDR unchanged, exactly one read_done_o.
REQ-036 arst_ni pulsed low while AW_VALID is high -> all outputs 0 asynchronously, no write_done_o afterwards, and a new write is accepted normally.
